cr_cp0_icache_inv: RTL

Sequencer in CP0 that services I-cache invalidation requests from the IU special unit (FENCE.I, ICALL invalidate-all, ICPA invalidate-by-address). It produces `cp0_iu_cache_inv_done`, which the IU special unit waits on before completing and flushing. Invalidate-all walks every I-cache index through a req/ack handshake. Invalidate-by-PA issues a single addressed request. Done is held until the IU drops the request.

---
 rtl/cr_cp0_pkg.sv | 29 ++
 rtl/cr_cp0_icache_inv_if.sv | 47 ++++
 rtl/cr_cp0_inv_idx_cnt.sv | 28 ++
 rtl/cr_cp0_icache_inv.sv | 126 ++++++++++++
 4 files changed

// File: rtl/cr_cp0_pkg.sv
// Shared CP0 cache-maintenance definitions: sequencer state encoding and defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cr_cp0_pkg;

    localparam int CR_LINE_NUM_DEF = 64;
    localparam int CR_ADDR_W_DEF   = 32;

    // 3-bit state codes, kept as plain localparams so other sequencers can share them
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WALK  = 3'd1;
    localparam logic [2:0] ST_PA    = 3'd2;
    localparam logic [2:0] ST_ABORT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_WALK  = ST_WALK,
        S_PA    = ST_PA,
        S_ABORT = ST_ABORT,
        S_DONE  = ST_DONE
    } inv_state_e;

    // States in which a request is being presented to the cache
    function automatic logic inv_state_busy(input inv_state_e s);
        return (s == S_WALK) || (s == S_PA) || (s == S_ABORT);
    endfunction

endpackage

// File: rtl/cr_cp0_icache_inv_if.sv
// IU <-> CP0 <-> I-cache invalidation signal bundle.
// Latency: n/a (wires only).
// Backpressure: cache side stalls the sequencer by withholding ack.
interface cr_cp0_icache_inv_if
    import cr_cp0_pkg::*;
#(
    parameter int IDX_W  = 6,
    parameter int ADDR_W = CR_ADDR_W_DEF
);
    // IU side
    logic              iu_cp0_inv_all_req;
    logic              iu_cp0_inv_pa_req;
    logic [ADDR_W-1:0] iu_cp0_inv_pa;
    logic              cp0_iu_cache_inv_done;
    // I-cache side
    logic              cp0_icache_inv_req;
    logic              cp0_icache_inv_pa_mode;
    logic [IDX_W-1:0]  cp0_icache_inv_idx;
    logic [ADDR_W-1:0] cp0_icache_inv_addr;
    logic              icache_cp0_inv_ack;

    // Environment view: drives IU requests and cache ack
    modport master (
        output iu_cp0_inv_all_req,
        output iu_cp0_inv_pa_req,
        output iu_cp0_inv_pa,
        output icache_cp0_inv_ack,
        input  cp0_iu_cache_inv_done,
        input  cp0_icache_inv_req,
        input  cp0_icache_inv_pa_mode,
        input  cp0_icache_inv_idx,
        input  cp0_icache_inv_addr
    );

    // Sequencer view
    modport slave (
        input  iu_cp0_inv_all_req,
        input  iu_cp0_inv_pa_req,
        input  iu_cp0_inv_pa,
        input  icache_cp0_inv_ack,
        output cp0_iu_cache_inv_done,
        output cp0_icache_inv_req,
        output cp0_icache_inv_pa_mode,
        output cp0_icache_inv_idx,
        output cp0_icache_inv_addr
    );
endinterface

// File: rtl/cr_cp0_inv_idx_cnt.sv
// Cache-index walk counter with clear, increment and terminal-count flag.
// Latency: count updates one cycle after clr/inc; tc is combinational from the count.
// Backpressure: none; the owner only pulses inc on an accepted request.
module cr_cp0_inv_idx_cnt #(
    parameter int LINE_NUM = 64,
    parameter int IDX_W    = $clog2(LINE_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] cnt,
    output logic             tc
);
    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(LINE_NUM - 1);

    // Clear has priority; the owner stops incrementing at tc so the count never wraps
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + IDX_W'(1);
        end
    end

    assign tc = (cnt == CNT_LAST);

endmodule

// File: rtl/cr_cp0_icache_inv.sv
// I-cache invalidation sequencer: invalidate-all index walk or single invalidate-by-PA.
// Latency: request seen -> cache req next cycle; done one cycle after the final ack.
// Backpressure: req/idx/addr held until ack; done held until the IU drops its request.
module cr_cp0_icache_inv
    import cr_cp0_pkg::*;
#(
    parameter int LINE_NUM = CR_LINE_NUM_DEF,
    parameter int IDX_W    = $clog2(LINE_NUM),
    parameter int ADDR_W   = CR_ADDR_W_DEF
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    cr_cp0_icache_inv_if.slave bus
);
    inv_state_e        state_q;
    inv_state_e        state_nxt;
    logic              addr_ld;
    logic              cnt_clr;
    logic              cnt_inc;
    logic [IDX_W-1:0]  cnt;
    logic              cnt_tc;
    logic              inv_req_q;
    logic              pa_mode_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;

    logic all_req;
    logic pa_req;
    logic ack;

    assign all_req = bus.iu_cp0_inv_all_req;
    assign pa_req  = bus.iu_cp0_inv_pa_req;
    assign ack     = bus.icache_cp0_inv_ack;

    cr_cp0_inv_idx_cnt #(
        .LINE_NUM (LINE_NUM),
        .IDX_W    (IDX_W)
    ) u_idx_cnt (
        .clk (forever_cpuclk),
        .rst (cpurst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (cnt),
        .tc  (cnt_tc)
    );

    // Next-state: start, walk/accept, squash handling and done release
    always_comb begin
        state_nxt = state_q;
        addr_ld   = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (all_req) begin
                    state_nxt = S_WALK;
                end else if (pa_req) begin
                    state_nxt = S_PA;
                    addr_ld   = 1'b1;
                end
            end
            S_WALK: begin
                if (!all_req) begin
                    // Squash: an in-flight request cannot be retracted, finish it silently
                    state_nxt = ack ? S_IDLE : S_ABORT;
                end else if (ack) begin
                    if (cnt_tc) begin
                        state_nxt = S_DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_PA: begin
                if (!pa_req) begin
                    state_nxt = ack ? S_IDLE : S_ABORT;
                end else if (ack) begin
                    state_nxt = S_DONE;
                end
            end
            S_ABORT: begin
                if (ack) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                // A request level change here is not a new instruction; wait for both low
                if (!all_req && !pa_req) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // Keep the index only while a walk (or its abort) is outstanding so idx reads 0 otherwise
        cnt_clr = !((state_nxt == S_WALK) || (state_nxt == S_ABORT));
    end

    // State and registered outputs, all derived from the next state
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q   <= S_IDLE;
            inv_req_q <= 1'b0;
            pa_mode_q <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_nxt;
            inv_req_q <= inv_state_busy(state_nxt);
            done_q    <= (state_nxt == S_DONE);
            pa_mode_q <= (state_nxt == S_PA) || ((state_nxt == S_ABORT) && pa_mode_q);
            if (addr_ld) begin
                addr_q <= bus.iu_cp0_inv_pa;
            end else if (!((state_nxt == S_PA) || (state_nxt == S_ABORT))) begin
                addr_q <= '0;
            end
        end
    end

    assign bus.cp0_iu_cache_inv_done  = done_q;
    assign bus.cp0_icache_inv_req     = inv_req_q;
    assign bus.cp0_icache_inv_pa_mode = pa_mode_q;
    assign bus.cp0_icache_inv_idx     = cnt;
    assign bus.cp0_icache_inv_addr    = addr_q;

endmodule
